// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with mid-bit sampling and a
// one-entry valid/ready output buffer with pulsed framing/overrun flags.
module uart_rx #(
  parameter int CLOCKS_PER_BIT = 234
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       framing_error,
  output logic       overrun
);

  localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_busy;
  logic          r_framingError;
  logic          r_overrun;
  logic          r_rxMeta;
  logic          r_rxSync;
  logic          w_rxS;

  // Idle-high line, so both synchronizer stages reset to 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= rx;
      r_rxSync <= r_rxMeta;
    end
  end

  assign w_rxS = r_rxSync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_bitCnt       <= '0;
      r_shift        <= '0;
      r_data         <= '0;
      r_valid        <= 1'b0;
      r_busy         <= 1'b0;
      r_framingError <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_framingError <= 1'b0;
      r_overrun      <= 1'b0;
      if (r_valid && ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxS) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt    <= '0;
            r_bitCnt <= '0;
            if (w_rxS) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt    <= '0;
            r_shift  <= {w_rxS, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            if (w_rxS) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              // A read in the completion cycle frees the buffer for the new byte.
              if (!r_valid || ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_framingError <= 1'b1;
              r_state        <= S_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_WAIT_IDLE: begin
          if (w_rxS) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign data          = r_data;
  assign valid         = r_valid;
  assign busy          = r_busy;
  assign framing_error = r_framingError;
  assign overrun       = r_overrun;

endmodule
